// File: rtl/cube_spawner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cube_spawner_pkg
// Description : Shared FallingCubes spawn parameters (column width, queue
//               depth, pacing defaults) plus the difficulty-level type and the
//               period step-down helper. The playfield and renderer import
//               this package as well.
// Revision    : 1.0 - initial release
// ============================================================================
package cube_spawner_pkg;

    localparam int DEF_COL_W            = 3;
    localparam int DEF_FIFO_DEPTH       = 4;
    localparam int DEF_SPAWN_PERIOD     = 50;
    localparam int DEF_MIN_PERIOD       = 10;
    localparam int DEF_PERIOD_STEP      = 4;
    localparam int DEF_SPAWNS_PER_LEVEL = 8;

    localparam int PERIOD_W = 8;
    localparam int LEVEL_W  = 4;

    typedef logic [LEVEL_W-1:0] level_t;
    localparam level_t MAX_LEVEL = 4'd15;

    // Shorten the spawn period by one step without dropping below the floor.
    // The compare is done in int so the subtraction can never wrap.
    function automatic logic [PERIOD_W-1:0] next_period(
        input logic [PERIOD_W-1:0] cur,
        input int                  step,
        input int                  floor_p
    );
        if (int'(cur) >= floor_p + step) begin
            return PERIOD_W'(int'(cur) - step);
        end
        return PERIOD_W'(floor_p);
    endfunction

endpackage : cube_spawner_pkg
`default_nettype wire

// File: rtl/cube_spawner_spawn_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spawn_fifo
// Description : Parameterized synchronous FIFO for cube spawn events. A push
//               is taken when the queue is not full, or when it is full and a
//               pop happens in the same cycle. The head word is a read-mux of
//               storage and reads as zero while the queue is empty.
// Ports       : clk_i    - clock
//               reset_i  - synchronous active-low reset
//               clear_i  - synchronous flush, overrides push and pop
//               push_i   - write request, data_i carries the word
//               pop_i    - consumer ready; pops only while valid_o is high
//               accept_o - push_i taken this cycle (combinational)
//               valid_o  - queue non-empty (registered)
//               full_o   - queue full (registered)
//               data_o   - head word, zero when empty
// Revision    : 1.0 - initial release
// ============================================================================
module spawn_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             accept_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;

    logic w_pop;
    logic w_push;

    assign w_pop  = pop_i && valid_q;
    // A full queue can still take a word when the head leaves this cycle.
    assign w_push = push_i && (!full_q || w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
        valid_d = (count_d != '0);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    // Storage needs no reset: entries are only visible through valid_q.
    always_ff @(posedge clk_i) begin
        if (w_push && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign accept_o = w_push && !clear_i;
    assign valid_o  = valid_q;
    assign full_o   = full_q;
    assign data_o   = valid_q ? mem_q[rd_ptr_q] : '0;

endmodule : spawn_fifo
`default_nettype wire

// File: rtl/cube_spawner.sv
`default_nettype none
// ============================================================================
// Module      : cube_spawner
// Description : Turns the LFSR word into a paced stream of cube spawn events.
//               A frame-tick timer fires one spawn per period, the random
//               word is mapped to a column with immediate repeats bumped to
//               the next column, and events are queued for the playfield.
//               Every SPAWNS_PER_LEVEL accepted spawns raise the level and
//               shorten the period down to a floor.
// Ports       : clk_i          - clock
//               reset_i        - synchronous active-low reset
//               rnd_i          - LFSR word, sampled on the spawn cycle
//               frame_tick_i   - one pulse per video frame
//               enable_i       - game running; timer frozen when low
//               restart_i      - soft restart, same effect as reset
//               spawn_ready_i  - consumer takes the head event
//               spawn_valid_o  - spawn queue non-empty
//               spawn_col_o    - column of the head event (0 when empty)
//               overflow_o     - sticky, a spawn was dropped on a full queue
//               level_o        - difficulty level, saturates at MAX_LEVEL
// Revision    : 1.0 - initial release
// ============================================================================
module cube_spawner
    import cube_spawner_pkg::*;
#(
    parameter int COL_W            = DEF_COL_W,
    parameter int SPAWN_PERIOD     = DEF_SPAWN_PERIOD,
    parameter int MIN_PERIOD       = DEF_MIN_PERIOD,
    parameter int PERIOD_STEP      = DEF_PERIOD_STEP,
    parameter int SPAWNS_PER_LEVEL = DEF_SPAWNS_PER_LEVEL,
    parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [8:0]       rnd_i,
    input  logic             frame_tick_i,
    input  logic             enable_i,
    input  logic             restart_i,
    input  logic             spawn_ready_i,
    output logic             spawn_valid_o,
    output logic [COL_W-1:0] spawn_col_o,
    output logic             overflow_o,
    output level_t           level_o
);

    localparam int CNT_W = 8;

    logic [PERIOD_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    level_t              level_q, level_d;
    logic [CNT_W-1:0]    spawn_count_q, spawn_count_d;
    logic                overflow_q, overflow_d;
    logic                has_last_q, has_last_d;
    logic [COL_W-1:0]    last_col_q, last_col_d;

    logic             w_tick;
    logic             w_fire;
    logic             w_accept;
    logic             w_fifo_full;
    logic [COL_W-1:0] w_raw;
    logic [COL_W-1:0] w_col;
    logic             w_unused_rnd;

    assign w_tick = frame_tick_i && enable_i;
    assign w_fire = w_tick && (tick_cnt_q == period_q - PERIOD_W'(1));

    // Only the low bits pick the column; a repeat of the previous column is
    // bumped by one and wraps naturally at the column-count boundary.
    assign w_raw        = rnd_i[COL_W-1:0];
    assign w_col        = (has_last_q && (w_raw == last_col_q)) ? w_raw + COL_W'(1) : w_raw;
    assign w_unused_rnd = ^rnd_i[8:COL_W];

    spawn_fifo #(
        .WIDTH (COL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_spawn_fifo (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (restart_i),
        .push_i   (w_fire),
        .pop_i    (spawn_ready_i),
        .data_i   (w_col),
        .accept_o (w_accept),
        .valid_o  (spawn_valid_o),
        .full_o   (w_fifo_full),
        .data_o   (spawn_col_o)
    );

    always_comb begin
        tick_cnt_d    = tick_cnt_q;
        period_d      = period_q;
        level_d       = level_q;
        spawn_count_d = spawn_count_q;
        overflow_d    = overflow_q;
        has_last_d    = has_last_q;
        last_col_d    = last_col_q;
        if (restart_i) begin
            tick_cnt_d    = '0;
            period_d      = PERIOD_W'(SPAWN_PERIOD);
            level_d       = '0;
            spawn_count_d = '0;
            overflow_d    = 1'b0;
            has_last_d    = 1'b0;
            last_col_d    = '0;
        end else begin
            if (w_tick) begin
                tick_cnt_d = w_fire ? '0 : tick_cnt_q + PERIOD_W'(1);
            end
            if (w_fire) begin
                if (w_accept) begin
                    last_col_d = w_col;
                    has_last_d = 1'b1;
                    if (spawn_count_q == CNT_W'(SPAWNS_PER_LEVEL - 1)) begin
                        // tick_cnt is cleared in this same cycle, so the
                        // shorter period never lands below a running count.
                        spawn_count_d = '0;
                        level_d       = (level_q == MAX_LEVEL) ? level_q : level_q + level_t'(1);
                        period_d      = next_period(period_q, PERIOD_STEP, MIN_PERIOD);
                    end else begin
                        spawn_count_d = spawn_count_q + CNT_W'(1);
                    end
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            tick_cnt_q    <= '0;
            period_q      <= PERIOD_W'(SPAWN_PERIOD);
            level_q       <= '0;
            spawn_count_q <= '0;
            overflow_q    <= 1'b0;
            has_last_q    <= 1'b0;
            last_col_q    <= '0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            period_q      <= period_d;
            level_q       <= level_d;
            spawn_count_q <= spawn_count_d;
            overflow_q    <= overflow_d;
            has_last_q    <= has_last_d;
            last_col_q    <= last_col_d;
        end
    end

    assign overflow_o = overflow_q;
    assign level_o    = level_q;

endmodule : cube_spawner
`default_nettype wire

// File: tb/tb_cube_spawner.sv
`default_nettype none
// ============================================================================
// Module      : tb_cube_spawner
// Description : Directed self-checking bench for cube_spawner: reset values,
//               first-spawn latency, column repeat suppression and wrap,
//               overflow on a full queue, push-on-full-with-pop, level-up
//               pacing with floor and saturation, and soft restart.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cube_spawner;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] rnd;
    logic       frame_tick;
    logic       enable;
    logic       restart;
    logic       spawn_ready;
    logic       spawn_valid;
    logic [2:0] spawn_col;
    logic       overflow;
    logic [3:0] level;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cube_spawner dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .rnd_i         (rnd),
        .frame_tick_i  (frame_tick),
        .enable_i      (enable),
        .restart_i     (restart),
        .spawn_ready_i (spawn_ready),
        .spawn_valid_o (spawn_valid),
        .spawn_col_o   (spawn_col),
        .overflow_o    (overflow),
        .level_o       (level)
    );

    // Inputs change and outputs are observed 1 time unit after each edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n, input logic [8:0] r);
        rnd        = r;
        frame_tick = 1'b1;
        for (int i = 0; i < n; i++) step();
        frame_tick = 1'b0;
    endtask

    task automatic pop_one();
        spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0;
    endtask

    function automatic int period_of(input int lvl);
        return (50 - 4 * lvl > 10) ? 50 - 4 * lvl : 10;
    endfunction

    task automatic test_reset();
        n_tests++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", spawn_valid); end
        n_tests++; if (spawn_col !== 3'd0)   begin n_fail++; $display("FAIL reset_col: got %0d want 0", spawn_col); end
        n_tests++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_tests++; if (level !== 4'd0)       begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    endtask

    task automatic test_first_spawn();
        ticks(49, 9'h0A3);
        n_tests++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL first_early: valid %b after 49 ticks, want 0", spawn_valid); end
        ticks(1, 9'h0A3);
        n_tests++; if (spawn_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", spawn_valid); end
        n_tests++; if (spawn_col !== 3'd3)   begin n_fail++; $display("FAIL first_col: got %0d want 3", spawn_col); end
        pop_one();
        n_tests++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL first_pop: valid %b want 0", spawn_valid); end
    endtask

    task automatic test_no_repeat();
        logic [8:0] rv [3];
        logic [2:0] ec [3];
        rv = '{9'h1F3, 9'h007, 9'h10F};
        ec = '{3'd4, 3'd7, 3'd0};
        for (int i = 0; i < 3; i++) begin
            ticks(50, rv[i]);
            n_tests++;
            if (spawn_valid !== 1'b1 || spawn_col !== ec[i]) begin
                n_fail++;
                $display("FAIL norepeat_%0d: valid %b col %0d, want valid 1 col %0d", i, spawn_valid, spawn_col, ec[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_overflow();
        logic [8:0] rv [4];
        logic [2:0] ec [4];
        rv = '{9'h001, 9'h002, 9'h0F5, 9'h006};
        ec = '{3'd1, 3'd2, 3'd5, 3'd6};
        spawn_ready = 1'b0;
        for (int i = 0; i < 4; i++) ticks(50, rv[i]);
        n_tests++; if (level !== 4'd1)     begin n_fail++; $display("FAIL ovf_level_up: got %0d want 1", level); end
        n_tests++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL ovf_before_drop: got %b want 0", overflow); end
        ticks(46, 9'h006);
        n_tests++; if (overflow !== 1'b1)  begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
        n_tests++; if (level !== 4'd1)     begin n_fail++; $display("FAIL ovf_level_hold: got %0d want 1", level); end
        spawn_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (spawn_valid !== 1'b1 || spawn_col !== ec[i]) begin
                n_fail++;
                $display("FAIL ovf_drain_%0d: valid %b col %0d, want valid 1 col %0d", i, spawn_valid, spawn_col, ec[i]);
            end
            step();
        end
        spawn_ready = 1'b0;
        n_tests++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: valid %b want 0", spawn_valid); end
        // The dropped spawn must not have moved last_col off 6, and the
        // interval at level 1 is 46 ticks.
        ticks(45, 9'h006);
        n_tests++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL lvl1_early: valid %b after 45 ticks, want 0", spawn_valid); end
        ticks(1, 9'h006);
        n_tests++;
        if (spawn_valid !== 1'b1 || spawn_col !== 3'd7) begin
            n_fail++;
            $display("FAIL ovf_last_col: valid %b col %0d, want valid 1 col 7", spawn_valid, spawn_col);
        end
        ticks(46, 9'h000);
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        n_tests++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", spawn_valid); end
        n_tests++; if (level !== 4'd0)       begin n_fail++; $display("FAIL mid_reset_level: got %0d want 0", level); end
        n_tests++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL mid_reset_overflow: got %b want 0", overflow); end
        ticks(49, 9'h000);
        n_tests++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_early: valid %b want 0", spawn_valid); end
        ticks(1, 9'h000);
        n_tests++;
        if (spawn_valid !== 1'b1 || spawn_col !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_reset_spawn: valid %b col %0d, want valid 1 col 0", spawn_valid, spawn_col);
        end
        pop_one();
    endtask

    task automatic test_full_with_pop();
        logic [2:0] ec [4];
        ec = '{3'd2, 3'd3, 3'd4, 3'd5};
        spawn_ready = 1'b0;
        for (int i = 1; i <= 4; i++) ticks(50, 9'(i));
        ticks(49, 9'h005);
        spawn_ready = 1'b1;
        ticks(1, 9'h005);
        spawn_ready = 1'b0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_overflow: got %b want 0", overflow); end
        spawn_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (spawn_valid !== 1'b1 || spawn_col !== ec[i]) begin
                n_fail++;
                $display("FAIL fullpop_drain_%0d: valid %b col %0d, want valid 1 col %0d", i, spawn_valid, spawn_col, ec[i]);
            end
            step();
        end
        spawn_ready = 1'b0;
        n_tests++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_drained: valid %b want 0", spawn_valid); end
    endtask

    task automatic test_levels();
        int lvl;
        int cnt;
        // Six spawns already accepted since the last reset.
        spawn_ready = 1'b1;
        ticks(50, 9'h011);
        ticks(50, 9'h022);
        n_tests++; if (level !== 4'd1) begin n_fail++; $display("FAIL level_1: got %0d want 1", level); end
        step();
        spawn_ready = 1'b0;
        ticks(45, 9'h033);
        n_tests++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL period46_early: valid %b want 0", spawn_valid); end
        ticks(1, 9'h033);
        n_tests++; if (spawn_valid !== 1'b1) begin n_fail++; $display("FAIL period46_fire: valid %b want 1", spawn_valid); end
        pop_one();
        lvl = 1;
        cnt = 1;
        spawn_ready = 1'b1;
        while (lvl < 10) begin
            ticks(period_of(lvl), 9'(lvl * 7 + cnt));
            cnt++;
            if (cnt == 8) begin
                cnt = 0;
                lvl++;
                n_tests++;
                if (level !== 4'(lvl)) begin n_fail++; $display("FAIL level_step: got %0d want %0d", level, lvl); end
            end
        end
        step();
        spawn_ready = 1'b0;
        ticks(9, 9'h044);
        n_tests++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL floor_early: valid %b want 0", spawn_valid); end
        ticks(1, 9'h044);
        n_tests++; if (spawn_valid !== 1'b1) begin n_fail++; $display("FAIL floor_fire: valid %b want 1", spawn_valid); end
        pop_one();
        cnt = 1;
        spawn_ready = 1'b1;
        while (lvl < 17) begin
            ticks(10, 9'(lvl * 5 + cnt));
            cnt++;
            if (cnt == 8) begin
                cnt = 0;
                lvl++;
            end
        end
        n_tests++; if (level !== 4'd15) begin n_fail++; $display("FAIL level_saturate: got %0d want 15", level); end
        step();
        spawn_ready = 1'b0;
    endtask

    task automatic test_restart();
        for (int i = 0; i < 4; i++) ticks(10, 9'(i + 1));
        ticks(10, 9'h006);
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL restart_pre_overflow: got %b want 1", overflow); end
        ticks(9, 9'h007);
        restart     = 1'b1;
        spawn_ready = 1'b1;
        ticks(1, 9'h007);
        restart     = 1'b0;
        spawn_ready = 1'b0;
        n_tests++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL restart_valid: got %b want 0", spawn_valid); end
        n_tests++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL restart_overflow: got %b want 0", overflow); end
        n_tests++; if (level !== 4'd0)       begin n_fail++; $display("FAIL restart_level: got %0d want 0", level); end
        n_tests++; if (spawn_col !== 3'd0)   begin n_fail++; $display("FAIL restart_col: got %0d want 0", spawn_col); end
        ticks(49, 9'h0A3);
        n_tests++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL restart_period_early: valid %b want 0", spawn_valid); end
        ticks(1, 9'h0A3);
        n_tests++;
        if (spawn_valid !== 1'b1 || spawn_col !== 3'd3) begin
            n_fail++;
            $display("FAIL restart_period_fire: valid %b col %0d, want valid 1 col 3", spawn_valid, spawn_col);
        end
    endtask

    initial begin
        reset       = 1'b0;
        rnd         = 9'h000;
        frame_tick  = 1'b0;
        enable      = 1'b1;
        restart     = 1'b0;
        spawn_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;

        test_reset();
        test_first_spawn();
        test_no_repeat();
        test_overflow();
        test_reset_mid();
        test_full_with_pop();
        test_levels();
        test_restart();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cube_spawner
`default_nettype wire

// File: doc/cube_spawner.md
# cube_spawner

Consumes the 9-bit pseudo-random word from the game's LFSR and turns it into a paced stream of cube spawn events for the FallingCubes playfield. A frame-tick-driven timer decides when a new cube appears. The random word is mapped to a column, with immediate repeats suppressed. Events are queued in a 4-entry FIFO that the playfield logic drains with a valid/ready handshake. Spawn rate increases with progress.

## Interface
- COL_W, 3: column index width; playfield has 2**COL_W columns
- SPAWN_PERIOD, 50: initial frame ticks between spawns (>= MIN_PERIOD, <= 255)
- MIN_PERIOD, 10: period floor (>= 1)
- PERIOD_STEP, 4: period decrement per level
- SPAWNS_PER_LEVEL, 8: accepted spawns per level-up
- FIFO_DEPTH, 4: spawn queue entries (power of two)

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low; state cleared on any clk edge with reset==0
- rnd  in  9  random word from LFSR, sampled on the spawn cycle
- frame_tick  in  1  one-cycle pulse per video frame
- enable  in  1  game running; timer frozen when 0
- restart  in  1  one-cycle soft restart (same effect as reset)
- spawn_ready  in  1  consumer accepts head event
- spawn_valid  out  1  FIFO non-empty
- spawn_col  out  COL_W  column of head event
- overflow  out  1  sticky: a spawn was dropped on full FIFO
- level  out  4  current difficulty level, saturates at 15

## Operation
- Reset/restart values: tick_cnt=0, period=SPAWN_PERIOD, level=0, spawn_count=0, FIFO empty, spawn_valid=0, spawn_col=0, overflow=0, has_last=0, last_col=0. restart wins over every other event in its cycle.
- Timer: on frame_tick && enable, if tick_cnt == period-1 then tick_cnt<=0 and a spawn fires; else tick_cnt++. No frame_tick, or enable=0: tick_cnt holds.
- Column: raw = rnd[COL_W-1:0]. If has_last && raw==last_col, col = raw+1 modulo 2**COL_W (so 7 wraps to 0 at COL_W=3); else col = raw.
- Push: the spawn is accepted if the FIFO is not full, or if it is full and spawn_valid && spawn_ready in the same cycle. An accepted spawn writes col and sets last_col=col and has_last=1. It also increments spawn_count.
- Drop: a spawn that is not accepted is discarded. It sets overflow=1 and leaves last_col, spawn_count and level unchanged. overflow clears only on reset or restart.
- Level-up: when an accepted spawn makes spawn_count reach SPAWNS_PER_LEVEL:
  - spawn_count <= 0.
  - level <= min(level+1, 15).
  - period <= max(period-PERIOD_STEP, MIN_PERIOD), with no underflow.
  - The new period applies from the next timer compare.
- If period shrinks below tick_cnt+1, the next tick compares against the new period. tick_cnt then counts up to 255 and wraps through 0 before it fires. This is allowed only if it is unreachable; it is unreachable because tick_cnt is cleared in the same cycle as every period change.
- Pop: spawn_valid && spawn_ready removes the head. spawn_col shows the next entry combinationally from FIFO storage. spawn_col is 0 when the FIFO is empty.
- Simultaneous push and pop on an empty FIFO: the pop is impossible because valid=0, so only the push happens.

## Timing
- Spawn latency: spawn_valid rises the cycle after the final frame_tick of a period.
- First spawn after reset with enable=1 comes on the SPAWN_PERIOD-th frame_tick.
- Sustained throughput: 1 pop per cycle.
- spawn_valid/spawn_col hold stable while spawn_valid && !spawn_ready.
- All outputs are registered, except spawn_col, which is a FIFO read-mux of registered storage.

## Structure
- Shared package holds:
  - COL_W, FIFO_DEPTH and the period defaults, reused by the playfield and renderer.
  - The 4-bit level type and its MAX_LEVEL=15 constant.
- One sub-module, spawn_fifo: a parameterized synchronous FIFO with a full/empty count and same-cycle push-on-full-with-pop. The timer, column mapping and difficulty logic stay in cube_spawner.

## Test plan
- Reset held low 3 cycles mid-operation with 2 entries queued -> next cycle spawn_valid=0, level=0, overflow=0; first spawn needs a full 50 frame_ticks.
- SPAWN_PERIOD=50, enable=1, rnd=9'h0A3 at the 50th frame_tick -> spawn_valid=1 next cycle, spawn_col=3.
- Two spawns with rnd low bits 3 then 3 -> cols 3, 4; then low bits 7 after a col-7 spawn -> col 0 (wrap).
- spawn_ready=0, 5 spawns -> 4 queued; 5th dropped; overflow=1; last_col is the 4th column. Repeat the full case with spawn_ready=1 on the spawn cycle -> accepted, overflow stays 0.
- 8 accepted spawns -> level=1 and next interval 46 ticks. After 10 levels -> period=10 (floor) and level=10. After 15+ levels -> level stays 15.
- restart pulse coincident with a spawn and a pop -> FIFO empty, period=50, no push recorded, overflow=0.
